// File: rtl/watch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : watch_ctrl
// Purpose  : Debounced push-button events, hh:mm:ss time keeping and RUN/SETUP
//            field editing with per-digit blank / decimal-point display masks.
// Revision : 1.0 - initial release
// ============================================================================
module watch_ctrl #(
  parameter int P_TICK_NUM  = 50000000,
  parameter int P_DEB_NUM   = 500000,
  parameter int P_BLINK_NUM = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw_mode,
  input  logic       i_sw_pos,
  input  logic       i_sw_inc,
  input  logic       i_sw_clr,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_mode,
  output logic [1:0] o_pos,
  output logic [5:0] o_blank,
  output logic [5:0] o_dp
);

  localparam int C_TICK_W  = (P_TICK_NUM  > 1) ? $clog2(P_TICK_NUM)  : 1;
  localparam int C_DEB_W   = (P_DEB_NUM   > 1) ? $clog2(P_DEB_NUM)   : 1;
  localparam int C_BLINK_W = (P_BLINK_NUM > 1) ? $clog2(P_BLINK_NUM) : 1;

  localparam logic [C_TICK_W-1:0]  C_TICK_LAST  = C_TICK_W'(P_TICK_NUM - 1);
  localparam logic [C_TICK_W-1:0]  C_TICK_HALF  = C_TICK_W'(P_TICK_NUM / 2);
  localparam logic [C_DEB_W-1:0]   C_DEB_LAST   = C_DEB_W'(P_DEB_NUM - 1);
  localparam logic [C_BLINK_W-1:0] C_BLINK_LAST = C_BLINK_W'(P_BLINK_NUM - 1);
  localparam logic [5:0]           C_DP_ON      = 6'b010100;

  localparam int C_BTN_MODE = 0;
  localparam int C_BTN_POS  = 1;
  localparam int C_BTN_INC  = 2;
  localparam int C_BTN_CLR  = 3;

  logic [3:0] w_sw_raw;
  logic [3:0] w_press;

  assign w_sw_raw = {i_sw_clr, i_sw_inc, i_sw_pos, i_sw_mode};

  // Buttons are active-low: everything resets to the released level so that
  // leaving reset never manufactures a press.
  for (genvar b = 0; b < 4; b++) begin : g_btn
    logic               sync1_q;
    logic               sync2_q;
    logic               deb_q;
    logic               deb_prev_q;
    logic               press_q;
    logic [C_DEB_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q    <= 1'b1;
        sync2_q    <= 1'b1;
        deb_q      <= 1'b1;
        deb_prev_q <= 1'b1;
        press_q    <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q <= w_sw_raw[b];
        sync2_q <= sync1_q;
        if (sync2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == C_DEB_LAST) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        deb_prev_q <= deb_q;
        press_q    <= deb_prev_q & ~deb_q;
      end
    end

    assign w_press[b] = press_q;
  end

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_SETUP = 1'b1
  } state_t;

  state_t                 state_q,  state_d;
  logic [C_TICK_W-1:0]    tick_q,   tick_d;
  logic [C_BLINK_W-1:0]   blink_q,  blink_d;
  logic                   hidden_q, hidden_d;
  logic [5:0]             sec_q,    sec_d;
  logic [5:0]             min_q,    min_d;
  logic [4:0]             hour_q,   hour_d;
  logic [1:0]             pos_q,    pos_d;
  logic [5:0]             blank_q,  blank_d;
  logic [5:0]             dp_q,     dp_d;

  logic w_mode_p;
  logic w_pos_p;
  logic w_inc_p;
  logic w_clr_p;
  logic w_tick;

  assign w_mode_p = w_press[C_BTN_MODE];
  assign w_pos_p  = w_press[C_BTN_POS];
  assign w_inc_p  = w_press[C_BTN_INC];
  assign w_clr_p  = w_press[C_BTN_CLR];
  assign w_tick   = (state_q == S_RUN) && (tick_q == C_TICK_LAST);

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    blink_d  = blink_q;
    hidden_d = hidden_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hour_d   = hour_q;
    pos_d    = pos_q;

    if (state_q == S_RUN) begin
      tick_d = w_tick ? '0 : tick_q + 1'b1;
      // Press priority is mode > clr > pos > inc; pos/inc do nothing in RUN.
      if (w_mode_p) begin
        state_d  = S_SETUP;
        pos_d    = 2'd0;
        hidden_d = 1'b0;
        blink_d  = '0;
        tick_d   = '0;
      end else if (w_clr_p) begin
        sec_d  = '0;
        min_d  = '0;
        hour_d = '0;
        tick_d = '0;
      end else if (w_tick) begin
        sec_d = inc60(sec_q);
        if (sec_q == 6'd59) begin
          min_d = inc60(min_q);
          if (min_q == 6'd59) begin
            hour_d = inc24(hour_q);
          end
        end
      end
    end else begin
      tick_d = '0;
      if (blink_q == C_BLINK_LAST) begin
        blink_d  = '0;
        hidden_d = ~hidden_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end

      if (w_mode_p) begin
        state_d = S_RUN;
      end else if (w_clr_p) begin
        case (pos_q)
          2'd0:    sec_d  = '0;
          2'd1:    min_d  = '0;
          default: hour_d = '0;
        endcase
      end else if (w_pos_p) begin
        pos_d = (pos_q == 2'd2) ? 2'd0 : pos_q + 2'd1;
      end else if (w_inc_p) begin
        case (pos_q)
          2'd0:    sec_d  = inc60(sec_q);
          2'd1:    min_d  = inc60(min_q);
          default: hour_d = inc24(hour_q);
        endcase
      end

      if (w_clr_p | w_pos_p | w_inc_p) begin
        hidden_d = 1'b0;
        blink_d  = '0;
      end
    end

    // Masks are built from next-state values so they move on the same edge.
    blank_d = '0;
    if ((state_d == S_SETUP) && hidden_d) begin
      case (pos_d)
        2'd0:    blank_d = 6'b000011;
        2'd1:    blank_d = 6'b001100;
        default: blank_d = 6'b110000;
      endcase
    end
    dp_d = ((state_d == S_SETUP) || (tick_d < C_TICK_HALF)) ? C_DP_ON : 6'b000000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      tick_q   <= '0;
      blink_q  <= '0;
      hidden_q <= 1'b0;
      sec_q    <= '0;
      min_q    <= '0;
      hour_q   <= '0;
      pos_q    <= '0;
      blank_q  <= '0;
      dp_q     <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      blink_q  <= blink_d;
      hidden_q <= hidden_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      hour_q   <= hour_d;
      pos_q    <= pos_d;
      blank_q  <= blank_d;
      dp_q     <= dp_d;
    end
  end

  assign o_sec   = sec_q;
  assign o_min   = min_q;
  assign o_hour  = hour_q;
  assign o_mode  = (state_q == S_SETUP);
  assign o_pos   = pos_q;
  assign o_blank = blank_q;
  assign o_dp    = dp_q;

endmodule
`default_nettype wire
